i2c_entity_master: RTL and testbench

- Single-channel I2C master that runs one register-addressed transaction per `start` pulse: 7-bit slave address, 16-bit register address, then up to 1023 data bytes written or read.
- Eight instances sit in the ToF communication block, one per time-of-flight sensor.
- Each instance drives its SCL/SDA pads through external tri-state buffers as an open-drain master.

---
 rtl/i2c_entity_master.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_i2c_entity_master.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_entity_master.sv
// i2c_entity_master: open-drain I2C master, one register-addressed transaction per start.
// Frame: START, addr+W, reg[15:8], reg[7:0], then either nb_of_bytes write bytes,
// or repeated START, addr+R and nb_of_bytes read bytes (last one NACKed), then STOP.
// Ports:
//   clock, reset (async active-low)
//   slave_adress, register_address, is_read, nb_of_bytes, start -> request (latched on accept)
//   data_in       write byte, sampled at Q0 of each data byte's first bit
//   ready, error_out, byte_done, rd_data, rd_valid -> status / read data
//   SCL_in/SDA_in pad levels; SCL_out/SDA_out tied 0; SCL_t/SDA_t 1 = release, 0 = drive low
// Optional macro: I2C_CLK_STRETCH_EN -- quarter counter holds while a released SCL reads low.
module i2c_entity_master #(
    parameter int unsigned QTR_DIV = 62
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [6:0]  slave_adress,
    input  logic [15:0] register_address,
    input  logic        is_read,
    input  logic [9:0]  nb_of_bytes,
    input  logic [7:0]  data_in,
    input  logic        start,
    output logic        ready,
    output logic        error_out,
    output logic        byte_done,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    input  logic        SCL_in,
    input  logic        SDA_in,
    output logic        SCL_out,
    output logic        SDA_out,
    output logic        SCL_t,
    output logic        SDA_t
);

    localparam int unsigned CNT_W = $clog2(QTR_DIV);

    localparam logic [3:0] IDLE   = 4'd0;
    localparam logic [3:0] START  = 4'd1;
    localparam logic [3:0] ADDR   = 4'd2;
    localparam logic [3:0] ACK    = 4'd3;
    localparam logic [3:0] REGH   = 4'd4;
    localparam logic [3:0] REGL   = 4'd5;
    localparam logic [3:0] WDATA  = 4'd6;
    localparam logic [3:0] RSTART = 4'd7;
    localparam logic [3:0] ADDR_R = 4'd8;
    localparam logic [3:0] RDATA  = 4'd9;
    localparam logic [3:0] MACK   = 4'd10;
    localparam logic [3:0] STOP   = 4'd11;

    logic [3:0]       state_q, state_d, prev_q, prev_d;
    logic [1:0]       qtr_q, qtr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       sh_q, sh_d;
    logic [6:0]       addr_q, addr_d;
    logic [15:0]      reg_q, reg_d;
    logic             rd_q, rd_d;
    logic [9:0]       rem_q, rem_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic             ready_q, ready_d;
    logic             byte_done_q, byte_done_d;
    logic             rd_valid_q, rd_valid_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             scl_t_q, scl_t_d;
    logic             sda_t_q, sda_t_d;
    logic             tick_c, hold_c;

    assign tick_c = (cnt_q == CNT_W'(QTR_DIV - 1));

`ifdef I2C_CLK_STRETCH_EN
    // A slave holding a released SCL low freezes bit timing.
    assign hold_c = scl_t_q && !SCL_in && (state_q != IDLE);
`else
    logic unused_scl_in;
    assign unused_scl_in = SCL_in;
    assign hold_c        = 1'b0;
`endif

    // SCL level for a given state/quarter; evaluated on the next state so SCL leads SDA by a clock.
    function automatic logic scl_lvl(input logic [3:0] st, input logic [1:0] q);
        case (st)
            IDLE, START:  scl_lvl = 1'b1;
            RSTART, STOP: scl_lvl = (q != 2'd0);
            default:      scl_lvl = q[1];
        endcase
    endfunction

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            prev_q      <= IDLE;
            qtr_q       <= 2'd0;
            cnt_q       <= '0;
            bit_q       <= 3'd7;
            sh_q        <= 8'h00;
            addr_q      <= 7'h00;
            reg_q       <= 16'h0000;
            rd_q        <= 1'b0;
            rem_q       <= 10'd0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            ready_q     <= 1'b1;
            byte_done_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= 8'h00;
            scl_t_q     <= 1'b1;
            sda_t_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            qtr_q       <= qtr_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            sh_q        <= sh_d;
            addr_q      <= addr_d;
            reg_q       <= reg_d;
            rd_q        <= rd_d;
            rem_q       <= rem_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            ready_q     <= ready_d;
            byte_done_q <= byte_done_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            scl_t_q     <= scl_t_d;
            sda_t_q     <= sda_t_d;
        end
    end

    // Next-state and output logic; all sequencing happens on quarter ticks.
    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        qtr_d       = qtr_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        sh_d        = sh_q;
        addr_d      = addr_q;
        reg_d       = reg_q;
        rd_d        = rd_q;
        rem_d       = rem_q;
        ack_d       = ack_q;
        err_d       = err_q;
        rd_data_d   = rd_data_q;
        byte_done_d = 1'b0;
        rd_valid_d  = 1'b0;

        if (state_q == IDLE) begin
            cnt_d = '0;
            qtr_d = 2'd0;
            if (start && ready_q) begin
                addr_d  = slave_adress;
                reg_d   = register_address;
                rd_d    = is_read;
                rem_d   = nb_of_bytes;
                sh_d    = {slave_adress, 1'b0};
                bit_d   = 3'd7;
                err_d   = 1'b0;
                state_d = START;
            end
        end else if (!hold_c) begin
            if (!tick_c) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                cnt_d = '0;
                qtr_d = qtr_q + 2'd1;
                case (state_q)
                    START: begin
                        if (qtr_q == 2'd2) begin
                            qtr_d   = 2'd0;
                            state_d = ADDR;
                        end
                    end
                    ADDR, REGH, REGL, WDATA, ADDR_R: begin
                        // Write data is captured at the end of Q0 so byte_done has time to refresh it.
                        if (state_q == WDATA && bit_q == 3'd7 && qtr_q == 2'd0) sh_d = data_in;
                        if (qtr_q == 2'd3) begin
                            sh_d = {sh_q[6:0], 1'b0};
                            if (bit_q == 3'd0) begin
                                prev_d  = state_q;
                                state_d = ACK;
                            end else begin
                                bit_d = bit_q - 3'd1;
                            end
                        end
                    end
                    ACK: begin
                        if (qtr_q == 2'd2) ack_d = !SDA_in;
                        if (qtr_q == 2'd3) begin
                            bit_d = 3'd7;
                            if (!ack_q) begin
                                err_d   = 1'b1;
                                state_d = STOP;
                            end else begin
                                case (prev_q)
                                    ADDR: begin
                                        sh_d    = reg_q[15:8];
                                        state_d = REGH;
                                    end
                                    REGH: begin
                                        sh_d    = reg_q[7:0];
                                        state_d = REGL;
                                    end
                                    REGL: begin
                                        if (rem_q == 10'd0) state_d = STOP;
                                        else if (rd_q)      state_d = RSTART;
                                        else                state_d = WDATA;
                                    end
                                    WDATA: begin
                                        byte_done_d = 1'b1;
                                        rem_d       = rem_q - 10'd1;
                                        state_d     = (rem_q == 10'd1) ? STOP : WDATA;
                                    end
                                    default: state_d = RDATA;
                                endcase
                            end
                        end
                    end
                    RSTART: begin
                        if (qtr_q == 2'd3) begin
                            sh_d    = {addr_q, 1'b1};
                            bit_d   = 3'd7;
                            state_d = ADDR_R;
                        end
                    end
                    RDATA: begin
                        if (qtr_q == 2'd2) begin
                            sh_d = {sh_q[6:0], SDA_in};
                            if (bit_q == 3'd0) begin
                                rd_data_d  = {sh_q[6:0], SDA_in};
                                rd_valid_d = 1'b1;
                            end
                        end
                        if (qtr_q == 2'd3) begin
                            if (bit_q == 3'd0) state_d = MACK;
                            else               bit_d   = bit_q - 3'd1;
                        end
                    end
                    MACK: begin
                        if (qtr_q == 2'd3) begin
                            rem_d   = rem_q - 10'd1;
                            bit_d   = 3'd7;
                            state_d = (rem_q == 10'd1) ? STOP : RDATA;
                        end
                    end
                    STOP: begin
                        if (qtr_q == 2'd3) state_d = IDLE;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end

        ready_d = (state_d == IDLE);
        scl_t_d = scl_lvl(state_d, qtr_d);

        // SDA follows the current quarter, i.e. one clock after SCL, giving hold time.
        case (state_q)
            START:                  sda_t_d = (qtr_q == 2'd0);
            ADDR, REGH, REGL, ADDR_R: sda_t_d = sh_q[7];
            WDATA:                  sda_t_d = (bit_q == 3'd7 && qtr_q == 2'd0) ? data_in[7] : sh_q[7];
            RSTART:                 sda_t_d = (qtr_q < 2'd2);
            MACK:                   sda_t_d = (rem_q == 10'd1);
            STOP:                   sda_t_d = qtr_q[1];
            default:                sda_t_d = 1'b1;
        endcase
    end

    assign ready     = ready_q;
    assign error_out = err_q;
    assign byte_done = byte_done_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign SCL_t     = scl_t_q;
    assign SDA_t     = sda_t_q;
    assign SCL_out   = 1'b0;
    assign SDA_out   = 1'b0;

endmodule

// File: tb/tb_i2c_entity_master.sv
// Bench for i2c_entity_master: a behavioural slave/bus monitor decodes the open-drain lines into
// START/STOP/byte+ack tokens which are compared against the frame expected for each request.
`timescale 1ns/1ps
module tb_i2c_entity_master;

    localparam int unsigned QDIV  = 4;
    localparam int          TOK_S = 'h1000;
    localparam int          TOK_P = 'h2000;
    localparam int          BUDGET = 6000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [6:0]  slave_adress = '0;
    logic [15:0] register_address = '0;
    logic        is_read = 1'b0;
    logic [9:0]  nb_of_bytes = '0;
    logic [7:0]  data_in = '0;
    logic        start = 1'b0;
    logic        ready, error_out, byte_done, rd_valid;
    logic [7:0]  rd_data;
    logic        SCL_out, SDA_out, SCL_t, SDA_t;
    logic        scl_pad, sda_pad;
    logic        s_drv = 1'b1;

    int n_chk  = 0;
    int n_fail = 0;

    // Slave / monitor state
    logic       mon_clr = 1'b1;
    logic [6:0] s_addr = '0;
    bit         s_present = 1'b1;
    logic [7:0] s_rd_arr [0:7];
    logic [7:0] wr_arr   [0:7];
    int         s_rd_idx = 0;
    int         wr_idx = 0;
    int         bitcnt = 0;
    logic [7:0] shreg = '0;
    bit         first = 1'b1;
    bit         addressed = 1'b0;
    bit         rd_phase = 1'b0;
    logic       scl_p = 1'b1;
    logic       sda_p = 1'b1;
    int         tok[$];
    int         got_rd[$];
    int         bd_cnt = 0;

    always #5 clock = ~clock;

    assign scl_pad = SCL_t ? 1'b1 : SCL_out;
    assign sda_pad = (SDA_t ? 1'b1 : SDA_out) & s_drv;

    i2c_entity_master #(.QTR_DIV(QDIV)) dut (
        .clock(clock), .reset(reset),
        .slave_adress(slave_adress), .register_address(register_address),
        .is_read(is_read), .nb_of_bytes(nb_of_bytes), .data_in(data_in),
        .start(start), .ready(ready), .error_out(error_out), .byte_done(byte_done),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .SCL_in(scl_pad), .SDA_in(sda_pad),
        .SCL_out(SCL_out), .SDA_out(SDA_out), .SCL_t(SCL_t), .SDA_t(SDA_t)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Behavioural I2C slave plus bus decoder, sampled on the falling clock edge.
    always @(negedge clock) begin
        if (mon_clr) begin
            tok.delete();
            got_rd.delete();
            bd_cnt    = 0;
            wr_idx    = 0;
            s_rd_idx  = 0;
            bitcnt    = 0;
            first     = 1'b1;
            addressed = 1'b0;
            rd_phase  = 1'b0;
            s_drv     = 1'b1;
        end else begin
            if (byte_done) begin
                bd_cnt++;
                wr_idx++;
            end
            if (rd_valid) got_rd.push_back(int'(rd_data));
            if (scl_p && scl_pad && sda_p && !sda_pad) begin
                tok.push_back(TOK_S);
                bitcnt   = 0;
                first    = 1'b1;
                rd_phase = 1'b0;
            end else if (scl_p && scl_pad && !sda_p && sda_pad) begin
                tok.push_back(TOK_P);
                rd_phase = 1'b0;
            end else if (!scl_p && scl_pad) begin
                if (bitcnt < 8) begin
                    shreg = {shreg[6:0], sda_pad};
                    bitcnt++;
                end else begin
                    tok.push_back((sda_pad ? 256 : 0) + int'(shreg));
                    if (first) begin
                        addressed = s_present && (shreg[7:1] == s_addr);
                        rd_phase  = addressed && shreg[0];
                        first     = 1'b0;
                    end else if (rd_phase) begin
                        s_rd_idx++;
                        if (sda_pad) rd_phase = 1'b0;
                    end
                    bitcnt = 0;
                end
            end else if (scl_p && !scl_pad) begin
                if (bitcnt == 8)
                    s_drv = rd_phase ? 1'b1
                          : !(first ? (s_present && (shreg[7:1] == s_addr)) : addressed);
                else if (rd_phase && s_rd_idx < 8)
                    s_drv = s_rd_arr[3'(s_rd_idx)][3'(7 - bitcnt)];
                else
                    s_drv = 1'b1;
            end
        end
        data_in = (wr_idx < 8) ? wr_arr[3'(wr_idx)] : 8'h00;
        scl_p   = scl_pad;
        sda_p   = sda_pad;
    end

    task automatic run_txn(input logic [6:0] a, input logic [15:0] r, input logic rd, input int n,
                           input bit present, input bit poke, input logic [7:0] d0, input logic [7:0] d1);
        int exp_tok[$];
        int exp_rd[$];
        int cyc;
        for (int i = 0; i < 8; i++) begin
            wr_arr[i]   = 8'($urandom);
            s_rd_arr[i] = 8'($urandom);
        end
        wr_arr[0] = d0; wr_arr[1] = d1;
        s_rd_arr[0] = d0; s_rd_arr[1] = d1;
        s_addr    = a;
        s_present = present;

        // Expected frame straight from the protocol description.
        exp_tok.push_back(TOK_S);
        if (!present) begin
            exp_tok.push_back(256 + int'({a, 1'b0}));
        end else begin
            exp_tok.push_back(int'({a, 1'b0}));
            exp_tok.push_back(int'(r[15:8]));
            exp_tok.push_back(int'(r[7:0]));
            if (rd && n > 0) begin
                exp_tok.push_back(TOK_S);
                exp_tok.push_back(int'({a, 1'b1}));
                for (int i = 0; i < n; i++) begin
                    exp_tok.push_back(int'(s_rd_arr[i]) + ((i == n - 1) ? 256 : 0));
                    exp_rd.push_back(int'(s_rd_arr[i]));
                end
            end else if (!rd) begin
                for (int i = 0; i < n; i++) exp_tok.push_back(int'(wr_arr[i]));
            end
        end
        exp_tok.push_back(TOK_P);

        mon_clr = 1'b1;
        tick(); tick();
        mon_clr = 1'b0;
        tick();
        slave_adress     = a;
        register_address = r;
        is_read          = rd;
        nb_of_bytes      = 10'(n);
        start            = 1'b1;
        tick();
        start = 1'b0;
        check("ready_drop", int'(ready), 0);
        check("err_clear", int'(error_out), 0);
        // Request fields were latched; disturb them.
        slave_adress     = 7'($urandom);
        register_address = 16'($urandom);
        is_read          = 1'($urandom);
        nb_of_bytes      = 10'($urandom);
        if (poke) begin
            repeat (50) tick();
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        cyc = 0;
        while (!ready && cyc < BUDGET) begin
            tick();
            cyc++;
        end
        check("done_timeout", int'(cyc < BUDGET), 1);
        repeat (2) tick();

        check("tok_cnt", tok.size(), exp_tok.size());
        for (int i = 0; i < exp_tok.size() && i < tok.size(); i++)
            check($sformatf("tok[%0d]", i), tok[i], exp_tok[i]);
        check("byte_done_cnt", bd_cnt, (present && !rd) ? n : 0);
        check("rd_cnt", got_rd.size(), exp_rd.size());
        for (int i = 0; i < exp_rd.size() && i < got_rd.size(); i++)
            check($sformatf("rd_data[%0d]", i), got_rd[i], exp_rd[i]);
        check("error_out", int'(error_out), present ? 0 : 1);
        check("ready_end", int'(ready), 1);
    endtask

    task automatic reset_mid();
        mon_clr = 1'b1;
        tick(); tick();
        mon_clr = 1'b0;
        slave_adress     = 7'h01;
        register_address = 16'h0000;
        is_read          = 1'b0;
        nb_of_bytes      = 10'd1;
        start            = 1'b1;
        tick();
        start = 1'b0;
        // Address 0x01 -> byte 0x02: SCL and SDA are both driven low here.
        repeat (94) tick();
        check("pre_rst_scl", int'(SCL_t), 0);
        #2 reset = 1'b0;
        #1;
        check("rst_scl_t", int'(SCL_t), 1);
        check("rst_sda_t", int'(SDA_t), 1);
        check("rst_ready", int'(ready), 1);
        check("rst_err", int'(error_out), 0);
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        repeat (3) tick();
        check("init_scl_t", int'(SCL_t), 1);
        check("init_sda_t", int'(SDA_t), 1);
        check("init_ready", int'(ready), 1);
        check("init_err", int'(error_out), 0);
        check("init_bd", int'(byte_done), 0);
        check("init_rv", int'(rd_valid), 0);
        check("init_rdata", int'(rd_data), 0);
        check("drive_zero", int'({SCL_out, SDA_out}), 0);
        reset = 1'b1;
        tick();

        run_txn(7'h11, 16'h0102, 1'b0, 1, 1'b1, 1'b0, 8'hA5, 8'h00);
        run_txn(7'h11, 16'h0010, 1'b1, 2, 1'b1, 1'b0, 8'h3C, 8'h7E);
        run_txn(7'h55, 16'h1234, 1'b0, 2, 1'b0, 1'b0, 8'h12, 8'h34);
        run_txn(7'h2B, 16'h4242, 1'b0, 3, 1'b1, 1'b1, 8'h81, 8'h18);
        reset_mid();
        run_txn(7'h11, 16'hBEEF, 1'b0, 0, 1'b1, 1'b0, 8'h00, 8'h00);
        run_txn(7'h40, 16'h00FF, 1'b1, 0, 1'b1, 1'b0, 8'h00, 8'h00);
        for (int t = 0; t < 10; t++)
            run_txn(7'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                    ($urandom_range(0, 5) != 0), ($urandom_range(0, 2) == 0),
                    8'($urandom), 8'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
